// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the frame-width data mask.
//  uart_mask_data(data, nbits): zeroes bits [7:nbits] for nbits 5..8; other nbits pass data unchanged.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int NBITS_MIN = 5;
  localparam int NBITS_MAX = 8;
  function automatic logic [UART_DATA_W-1:0] uart_mask_data(input logic [UART_DATA_W-1:0] data, input logic [3:0] nbits);
    logic [UART_DATA_W-1:0] m;
    m = (int'(nbits) >= NBITS_MIN && int'(nbits) <= NBITS_MAX) ? 8'hFF >> (4'd8 - nbits) : 8'hFF;
    return data & m;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: DEPTH x 8 show-ahead FIFO with fill count and level flags.
//  Clk/Rst_n clock and async active-low reset; WrEn/WrData write (caller guarantees room);
//  RdEn pop (caller guarantees not empty); RdData head byte (0 while empty);
//  Count fill level; Full/Empty/AlmostFull/RdValid decoded from the registered Count.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   WrEn,
  input  logic [UART_DATA_W-1:0] WrData,
  input  logic                   RdEn,
  output logic [UART_DATA_W-1:0] RdData,
  output logic                   RdValid,
  output logic [AW:0]            Count,
  output logic                   Full,
  output logic                   Empty,
  output logic                   AlmostFull
);
  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Count <= '0;
    end else begin
      if (WrEn) wrPtr <= wrPtr + AW'(1);
      if (RdEn) rdPtr <= rdPtr + AW'(1);
      Count <= Count + (AW+1)'(WrEn) - (AW+1)'(RdEn);
    end
  always_ff @(posedge Clk)
    if (WrEn) mem[wrPtr] <= WrData;
  // Empty gates the head so RdData reads 0 after reset instead of unreset storage.
  always_comb begin
    Empty = Count == '0;
    Full = Count == DEPTH[AW:0];
    AlmostFull = Count >= AFULL_LVL[AW:0];
    RdValid = !Empty;
    RdData = Empty ? '0 : mem[rdPtr];
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures UART_rx bytes on RxDone rising edges, masks to NBits, queues them.
//  Clk/Rst_n clock and async active-low reset; RxDone/RxData/NBits from UART_rx;
//  RdData/RdValid/RdReady show-ahead host read port; Count/Full/Empty/AlmostFull fill status;
//  Overrun sticky dropped-byte flag, cleared by OvrClr.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   RxDone,
  input  logic [UART_DATA_W-1:0] RxData,
  input  logic [3:0]             NBits,
  output logic [UART_DATA_W-1:0] RdData,
  output logic                   RdValid,
  input  logic                   RdReady,
  output logic [AW:0]            Count,
  output logic                   Full,
  output logic                   Empty,
  output logic                   AlmostFull,
  output logic                   Overrun,
  input  logic                   OvrClr
);
  logic rxDoneQ, push, pop, accept, drop;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  always_comb begin
    push = RxDone & ~rxDoneQ;
    pop = RdValid & RdReady;
    accept = push & (~Full | pop);
    drop = push & ~accept;
  end
  // rxDoneQ resets high so RxDone already high at reset release is not an edge.
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      rxDoneQ <= 1'b1;
      Overrun <= 1'b0;
    end else begin
      rxDoneQ <= RxDone;
      Overrun <= drop ? 1'b1 : OvrClr ? 1'b0 : Overrun;
    end
  uart_sync_fifo #(.DEPTH(DEPTH), .AW(AW), .AFULL_LVL(AFULL_LVL)) fifo (
    .Clk(Clk), .Rst_n(Rst_n),
    .WrEn(accept), .WrData(uart_mask_data(RxData, NBits)),
    .RdEn(pop), .RdData(RdData), .RdValid(RdValid),
    .Count(Count), .Full(Full), .Empty(Empty), .AlmostFull(AlmostFull)
  );
endmodule
